cic3_decimator_datapath: RTL and testbench

- Third-order CIC decimation datapath.
- Consumes the 1-bit delta-sigma modulator bitstream at the modulator clock.
- Decimates by DECIMATION_FACTOR using the shared divided clock from the clock divider as its decimation timing reference.
- Presents decimated words to the downstream readout through a valid/ready handshake; several instances share one divider.

---
 rtl/cic_pkg.sv | 16 +
 rtl/cic3_comb_stage.sv | 26 ++
 rtl/cic3_decimator_datapath.sv | 130 +++++++++++++
 tb/tb_cic3_decimator_datapath.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared constants and width helpers for the CIC decimator family.
// Datapath width must hold the full-scale gain D^3 of a third-order filter.
package cic_pkg;

    localparam int DEFAULT_DECIMATION_FACTOR = 256;
    localparam int SETTLE_TICKS              = 3;
    localparam int CIC_ORDER                 = 3;

    typedef logic [1:0] settle_cnt_t;

    // Width needed for an order-3 CIC with a 1-bit input: 3*log2(D) + 1.
    function automatic int cic_numbits(input int clock_width);
        return CIC_ORDER * clock_width + 1;
    endfunction

endpackage

// File: rtl/cic3_comb_stage.sv
// One CIC differentiator: y = x - x_delayed, delay updated on the decimated tick.
// Output is combinational so several stages chain within one clock.
module cic3_comb_stage #(
    parameter int WIDTH = 25
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en_i,
    input  logic [WIDTH-1:0] x_i,
    output logic [WIDTH-1:0] y_o
);

    logic [WIDTH-1:0] delay_q;

    // Modular subtraction: integrator wrap-around cancels out here.
    assign y_o = x_i - delay_q;

    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            delay_q <= '0;
        end else if (en_i) begin
            delay_q <= x_i;
        end
    end

endmodule

// File: rtl/cic3_decimator_datapath.sv
// Third-order CIC decimator for a 1-bit delta-sigma stream, clocked on negedge,
// decimation timed by a shared divider MSB, output through valid/ready.
module cic3_decimator_datapath
    import cic_pkg::*;
#(
    parameter int DECIMATION_FACTOR = DEFAULT_DECIMATION_FACTOR,
    parameter int CLOCK_WIDTH       = $clog2(DECIMATION_FACTOR),
    parameter int NUMBITS           = cic_numbits(CLOCK_WIDTH)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               mod_bit,
    input  logic               divided_clk,
    input  logic               data_ready,
    output logic [NUMBITS-1:0] data_out,
    output logic               data_valid,
    output logic               overrun
);

    localparam int          NSTAGES    = CIC_ORDER;
    localparam settle_cnt_t SETTLE_MAX = settle_cnt_t'(SETTLE_TICKS);

    logic [NUMBITS-1:0] integ_q  [NSTAGES];
    logic [NUMBITS-1:0] integ_d  [NSTAGES];
    logic [NUMBITS-1:0] integ_in [NSTAGES];
    logic [NUMBITS-1:0] comb_x   [NSTAGES+1];

    logic               divided_clk_q;
    settle_cnt_t        settle_q;
    settle_cnt_t        settle_d;
    logic [NUMBITS-1:0] data_out_q;
    logic [NUMBITS-1:0] data_out_d;
    logic               data_valid_q;
    logic               data_valid_d;
    logic               overrun_q;
    logic               overrun_d;

    logic               tick;
    logic               settled;
    logic               load;
    logic               accept;

    // Integrator chain: each stage adds the previous-cycle value of the stage before.
    assign integ_in[0] = {{(NUMBITS-1){1'b0}}, mod_bit};

    genvar gi;
    generate
        for (gi = 1; gi < NSTAGES; gi++) begin : g_integ_link
            assign integ_in[gi] = integ_q[gi-1];
        end
        for (gi = 0; gi < NSTAGES; gi++) begin : g_integ_sum
            assign integ_d[gi] = integ_q[gi] + integ_in[gi];
        end
    endgenerate

    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NSTAGES; k++) begin
                integ_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NSTAGES; k++) begin
                integ_q[k] <= integ_d[k];
            end
        end
    end

    assign tick = divided_clk & ~divided_clk_q;

    // Comb chain is fully combinational from i3; only data_out registers it.
    assign comb_x[0] = integ_q[NSTAGES-1];

    generate
        for (gi = 0; gi < NSTAGES; gi++) begin : g_comb
            cic3_comb_stage #(
                .WIDTH (NUMBITS)
            ) u_comb (
                .clk     (clk),
                .reset_n (reset_n),
                .en_i    (tick),
                .x_i     (comb_x[gi]),
                .y_o     (comb_x[gi+1])
            );
        end
    endgenerate

    // The first results after reset see partially filled comb delays; drop them.
    assign settled  = (settle_q == SETTLE_MAX);
    assign settle_d = (tick && !settled) ? settle_q + settle_cnt_t'(1) : settle_q;

    assign load   = tick & settled;
    assign accept = data_valid_q & data_ready;

    always_comb begin
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;
        overrun_d    = overrun_q;
        if (accept) begin
            data_valid_d = 1'b0;
        end
        if (load) begin
            data_out_d   = comb_x[NSTAGES];
            data_valid_d = 1'b1;
            if (data_valid_q && !data_ready) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            divided_clk_q <= 1'b0;
            settle_q      <= '0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            divided_clk_q <= divided_clk;
            settle_q      <= settle_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            overrun_q     <= overrun_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_cic3_decimator_datapath.sv
// Directed bench for the CIC3 decimator: steady-state gain table plus
// hand-written settle, overrun, load-with-accept and async reset sequences.
module tb_cic3_decimator_datapath;

    localparam int D  = 256;
    localparam int NB = 25;

    localparam logic [NB-1:0] FULL = 25'd16777216;
    localparam logic [NB-1:0] HALF = 25'd8388608;
    localparam logic [NB-1:0] ZERO = 25'd0;

    logic          clk         = 1'b0;
    logic          reset_n     = 1'b0;
    logic          mod_bit     = 1'b0;
    logic          divided_clk = 1'b0;
    logic          data_ready  = 1'b0;
    logic [NB-1:0] data_out;
    logic          data_valid;
    logic          overrun;

    int   pass_cnt = 0;
    int   chk_cnt  = 0;
    int   tick_num = 0;
    logic dprev    = 1'b0;
    int   div_cnt  = 0;
    int   mode     = 0;

    typedef struct {
        int            mode;
        logic          ready;
        int            nticks;
        logic [NB-1:0] exp_data;
        logic          exp_valid;
        logic          exp_ov;
    } vec_t;

    vec_t vecs [7];

    cic3_decimator_datapath #(
        .DECIMATION_FACTOR (D)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .mod_bit     (mod_bit),
        .divided_clk (divided_clk),
        .data_ready  (data_ready),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // Divider model and tick counter; divider output moves just after negedge.
    always @(negedge clk) begin
        if (!reset_n) begin
            tick_num = 0;
            dprev    = 1'b0;
        end else begin
            if (divided_clk && !dprev) tick_num++;
            dprev = divided_clk;
        end
        #1;
        if (!reset_n) div_cnt = 0;
        else          div_cnt = (div_cnt + 1) % D;
        divided_clk = (div_cnt >= D/2);
    end

    // Bitstream source: 0 = all zeros, 1 = all ones, 2 = alternating.
    always @(posedge clk) begin
        case (mode)
            0:       mod_bit = 1'b0;
            1:       mod_bit = 1'b1;
            default: mod_bit = ~mod_bit;
        endcase
    end

    task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic wait_ticks(input int n);
        int target;
        int budget;
        target = tick_num + n;
        budget = (n + 1) * D * 2;
        while (tick_num < target && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (tick_num < target) begin
            chk_cnt++;
            $display("FAIL tick_timeout: got %0d ticks expected %0d", tick_num, target);
        end
    endtask

    // Returns at the posedge immediately before the negedge that sees a tick.
    task automatic wait_pre_tick();
        int budget;
        budget = 2 * D;
        do begin
            @(posedge clk);
            budget--;
        end while (!(divided_clk && !dprev) && budget > 0);
        if (!(divided_clk && !dprev)) begin
            chk_cnt++;
            $display("FAIL pre_tick_timeout: got no rising divided_clk expected one within %0d cycles", 2 * D);
        end
    endtask

    initial begin
        vecs[0] = '{1, 1'b1, 5, FULL, 1'b1, 1'b0};
        vecs[1] = '{1, 1'b1, 2, FULL, 1'b1, 1'b0};
        vecs[2] = '{2, 1'b1, 5, HALF, 1'b1, 1'b0};
        vecs[3] = '{2, 1'b1, 2, HALF, 1'b1, 1'b0};
        vecs[4] = '{0, 1'b1, 5, ZERO, 1'b1, 1'b0};
        vecs[5] = '{1, 1'b1, 5, FULL, 1'b1, 1'b0};
        vecs[6] = '{0, 1'b1, 5, ZERO, 1'b1, 1'b0};

        // Reset and settling with an all-zero stream.
        reset_n    = 1'b0;
        mode       = 0;
        data_ready = 1'b1;
        repeat (5) @(posedge clk);
        chk("rst_data", data_out, ZERO);
        chk_bit("rst_valid", data_valid, 1'b0);
        chk_bit("rst_overrun", overrun, 1'b0);
        #2 reset_n = 1'b1;

        for (int t = 1; t <= 3; t++) begin
            wait_ticks(1);
            chk_bit($sformatf("settle_valid_t%0d", t), data_valid, 1'b0);
        end
        wait_ticks(1);
        chk_bit("first_valid_t4", data_valid, 1'b1);
        chk("first_data_t4", data_out, ZERO);
        chk_bit("first_overrun_t4", overrun, 1'b0);

        // Steady-state gain table; runs long enough for the integrators to wrap.
        for (int i = 0; i < 7; i++) begin
            mode       = vecs[i].mode;
            data_ready = vecs[i].ready;
            wait_ticks(vecs[i].nticks);
            chk($sformatf("vec%0d_data", i), data_out, vecs[i].exp_data);
            chk_bit($sformatf("vec%0d_valid", i), data_valid, vecs[i].exp_valid);
            chk_bit($sformatf("vec%0d_overrun", i), overrun, vecs[i].exp_ov);
        end

        // Accept clears valid, then back-to-back loads without ready overrun.
        @(posedge clk);
        chk_bit("accept_valid_drop", data_valid, 1'b0);
        data_ready = 1'b0;
        mode       = 1;
        wait_ticks(1);
        chk_bit("load_idle_valid", data_valid, 1'b1);
        chk_bit("load_idle_overrun", overrun, 1'b0);
        wait_ticks(5);
        chk("overrun_data_latest", data_out, FULL);
        chk_bit("overrun_valid", data_valid, 1'b1);
        chk_bit("overrun_set", overrun, 1'b1);
        data_ready = 1'b1;
        @(posedge clk);
        data_ready = 1'b0;
        chk_bit("overrun_accept_valid", data_valid, 1'b0);
        chk_bit("overrun_accept_sticky", overrun, 1'b1);
        chk("overrun_accept_hold", data_out, FULL);
        repeat (10) @(posedge clk);
        chk_bit("overrun_sticky_later", overrun, 1'b1);

        // Asynchronous reset between clock edges.
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("async_rst_data", data_out, ZERO);
        chk_bit("async_rst_valid", data_valid, 1'b0);
        chk_bit("async_rst_overrun", overrun, 1'b0);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;

        for (int t = 1; t <= 3; t++) begin
            wait_ticks(1);
            chk_bit($sformatf("re_settle_valid_t%0d", t), data_valid, 1'b0);
        end
        wait_ticks(1);
        chk_bit("re_first_valid", data_valid, 1'b1);
        chk("re_first_data", data_out, FULL);
        chk_bit("re_first_overrun", overrun, 1'b0);

        // Ready asserted exactly on the tick cycle: replace, no overrun.
        wait_pre_tick();
        data_ready = 1'b1;
        @(posedge clk);
        data_ready = 1'b0;
        chk_bit("load_accept_valid", data_valid, 1'b1);
        chk_bit("load_accept_overrun", overrun, 1'b0);
        chk("load_accept_data", data_out, FULL);
        wait_ticks(1);
        chk_bit("load_after_unaccepted_overrun", overrun, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
